// File: rtl/mem_access_stage.sv
// MEM stage of the RISC-TOY pipeline: performs one data-memory access per instruction
// over a DREQ/DACK handshake, passes ALU results through, and aborts hung accesses.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [4:0]        Write_Addr,
    input  logic [DATA_W-1:0] Result,
    input  logic [DATA_W-1:0] Store_data,
    output logic              DREQ,
    output logic              DRW,
    output logic [ADDR_W-1:0] DADDR,
    output logic [DATA_W-1:0] DWDATA,
    input  logic [DATA_W-1:0] DRDATA,
    input  logic              DACK,
    output logic              out_valid,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [4:0]        Write_Addr_out,
    output logic [DATA_W-1:0] Result_out,
    output logic [DATA_W-1:0] Read_data_out,
    output logic              Mem_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t              r_state, w_state_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;

    // Instruction fields held while the access is outstanding
    logic                r_lat_regwrite, w_lat_regwrite_nxt;
    logic                r_lat_memtoreg, w_lat_memtoreg_nxt;
    logic                r_lat_memread,  w_lat_memread_nxt;
    logic [4:0]          r_lat_waddr,    w_lat_waddr_nxt;
    logic [DATA_W-1:0]   r_lat_result,   w_lat_result_nxt;

    logic                r_dreq,   w_dreq_nxt;
    logic                r_drw,    w_drw_nxt;
    logic [ADDR_W-1:0]   r_daddr,  w_daddr_nxt;
    logic [DATA_W-1:0]   r_dwdata, w_dwdata_nxt;

    logic                r_out_valid, w_out_valid_nxt;
    logic                r_regwrite_out, w_regwrite_out_nxt;
    logic                r_memtoreg_out, w_memtoreg_out_nxt;
    logic [4:0]          r_waddr_out, w_waddr_out_nxt;
    logic [DATA_W-1:0]   r_result_out, w_result_out_nxt;
    logic [DATA_W-1:0]   r_rdata_out, w_rdata_out_nxt;
    logic                r_mem_err, w_mem_err_nxt;

    always_comb begin
        w_state_nxt         = r_state;
        w_timer_nxt         = r_timer;
        w_lat_regwrite_nxt  = r_lat_regwrite;
        w_lat_memtoreg_nxt  = r_lat_memtoreg;
        w_lat_memread_nxt   = r_lat_memread;
        w_lat_waddr_nxt     = r_lat_waddr;
        w_lat_result_nxt    = r_lat_result;
        w_dreq_nxt          = r_dreq;
        w_drw_nxt           = r_drw;
        w_daddr_nxt         = r_daddr;
        w_dwdata_nxt        = r_dwdata;
        w_out_valid_nxt     = 1'b0;
        w_regwrite_out_nxt  = 1'b0;
        w_mem_err_nxt       = 1'b0;
        w_memtoreg_out_nxt  = r_memtoreg_out;
        w_waddr_out_nxt     = r_waddr_out;
        w_result_out_nxt    = r_result_out;
        w_rdata_out_nxt     = r_rdata_out;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (MemRead == MemWrite) begin
                        // Both clear: ALU pass-through; both set: illegal, flagged without access
                        w_out_valid_nxt    = 1'b1;
                        w_mem_err_nxt      = MemRead;
                        w_regwrite_out_nxt = RegWrite & ~MemRead;
                        w_memtoreg_out_nxt = MemtoReg;
                        w_waddr_out_nxt    = Write_Addr;
                        w_result_out_nxt   = Result;
                        w_rdata_out_nxt    = '0;
                    end else begin
                        w_lat_regwrite_nxt = RegWrite;
                        w_lat_memtoreg_nxt = MemtoReg;
                        w_lat_memread_nxt  = MemRead;
                        w_lat_waddr_nxt    = Write_Addr;
                        w_lat_result_nxt   = Result;
                        w_dreq_nxt         = 1'b1;
                        w_drw_nxt          = MemWrite;
                        w_daddr_nxt        = Result[ADDR_W-1:0];
                        w_dwdata_nxt       = Store_data;
                        w_timer_nxt        = '0;
                        w_state_nxt        = REQ;
                    end
                end
            end
            REQ: begin
                if (DACK || (r_timer == TMAX)) begin
                    w_dreq_nxt         = 1'b0;
                    w_state_nxt        = IDLE;
                    w_timer_nxt        = '0;
                    w_out_valid_nxt    = 1'b1;
                    w_mem_err_nxt      = ~DACK;
                    w_regwrite_out_nxt = r_lat_regwrite & DACK;
                    w_memtoreg_out_nxt = r_lat_memtoreg;
                    w_waddr_out_nxt    = r_lat_waddr;
                    w_result_out_nxt   = r_lat_result;
                    w_rdata_out_nxt    = (DACK && r_lat_memread) ? DRDATA : '0;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= IDLE;
            r_timer        <= '0;
            r_lat_regwrite <= 1'b0;
            r_lat_memtoreg <= 1'b0;
            r_lat_memread  <= 1'b0;
            r_lat_waddr    <= '0;
            r_lat_result   <= '0;
            r_dreq         <= 1'b0;
            r_drw          <= 1'b0;
            r_daddr        <= '0;
            r_dwdata       <= '0;
            r_out_valid    <= 1'b0;
            r_regwrite_out <= 1'b0;
            r_memtoreg_out <= 1'b0;
            r_waddr_out    <= '0;
            r_result_out   <= '0;
            r_rdata_out    <= '0;
            r_mem_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_timer        <= w_timer_nxt;
            r_lat_regwrite <= w_lat_regwrite_nxt;
            r_lat_memtoreg <= w_lat_memtoreg_nxt;
            r_lat_memread  <= w_lat_memread_nxt;
            r_lat_waddr    <= w_lat_waddr_nxt;
            r_lat_result   <= w_lat_result_nxt;
            r_dreq         <= w_dreq_nxt;
            r_drw          <= w_drw_nxt;
            r_daddr        <= w_daddr_nxt;
            r_dwdata       <= w_dwdata_nxt;
            r_out_valid    <= w_out_valid_nxt;
            r_regwrite_out <= w_regwrite_out_nxt;
            r_memtoreg_out <= w_memtoreg_out_nxt;
            r_waddr_out    <= w_waddr_out_nxt;
            r_result_out   <= w_result_out_nxt;
            r_rdata_out    <= w_rdata_out_nxt;
            r_mem_err      <= w_mem_err_nxt;
        end
    end

    assign in_ready       = (r_state == IDLE);
    assign DREQ           = r_dreq;
    assign DRW            = r_drw;
    assign DADDR          = r_daddr;
    assign DWDATA         = r_dwdata;
    assign out_valid      = r_out_valid;
    assign RegWrite_out   = r_regwrite_out;
    assign MemtoReg_out   = r_memtoreg_out;
    assign Write_Addr_out = r_waddr_out;
    assign Result_out     = r_result_out;
    assign Read_data_out  = r_rdata_out;
    assign Mem_err        = r_mem_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a driver issues instructions and plays the memory,
// pushing expected WB results into a queue that an independent monitor drains.
module tb_mem_access_stage;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic              RegWrite = 1'b0;
    logic              MemtoReg = 1'b0;
    logic [4:0]        Write_Addr = '0;
    logic [DATA_W-1:0] Result = '0;
    logic [DATA_W-1:0] Store_data = '0;
    logic              DREQ;
    logic              DRW;
    logic [ADDR_W-1:0] DADDR;
    logic [DATA_W-1:0] DWDATA;
    logic [DATA_W-1:0] DRDATA = '0;
    logic              DACK = 1'b0;
    logic              out_valid;
    logic              RegWrite_out;
    logic              MemtoReg_out;
    logic [4:0]        Write_Addr_out;
    logic [DATA_W-1:0] Result_out;
    logic [DATA_W-1:0] Read_data_out;
    logic              Mem_err;

    mem_access_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .Write_Addr(Write_Addr), .Result(Result), .Store_data(Store_data),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .DRDATA(DRDATA), .DACK(DACK),
        .out_valid(out_valid), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .Write_Addr_out(Write_Addr_out), .Result_out(Result_out),
        .Read_data_out(Read_data_out), .Mem_err(Mem_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [4:0]  wa;
        logic [31:0] res;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (!RST) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got out_valid=1 expected no output (t=%0t)", $time);
                end else begin
                    me = q.pop_front();
                    chk("out_cycle", 32'(cyc), 32'(me.cyc));
                    chk("RegWrite_out", 32'(RegWrite_out), 32'(me.rw));
                    chk("MemtoReg_out", 32'(MemtoReg_out), 32'(me.mtr));
                    chk("Write_Addr_out", 32'(Write_Addr_out), 32'(me.wa));
                    chk("Result_out", Result_out, me.res);
                    chk("Read_data_out", Read_data_out, me.rd);
                    chk("Mem_err", 32'(Mem_err), 32'(me.err));
                end
            end else begin
                chk("RegWrite_out_idle", 32'(RegWrite_out), 32'd0);
                chk("Mem_err_idle", 32'(Mem_err), 32'd0);
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_DREQ", 32'(DREQ), 32'd0);
        chk("rst_DRW", 32'(DRW), 32'd0);
        chk("rst_DADDR", DADDR, 32'd0);
        chk("rst_DWDATA", DWDATA, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_RegWrite_out", 32'(RegWrite_out), 32'd0);
        chk("rst_MemtoReg_out", 32'(MemtoReg_out), 32'd0);
        chk("rst_Write_Addr_out", 32'(Write_Addr_out), 32'd0);
        chk("rst_Result_out", Result_out, 32'd0);
        chk("rst_Read_data_out", Read_data_out, 32'd0);
        chk("rst_Mem_err", 32'(Mem_err), 32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
    endtask

    // kind: 0 = ALU, 1 = illegal, 2 = load, 3 = store; d = REQ cycle in which DACK is given
    task automatic do_txn(input int kind, input logic rw, input logic mtr, input logic [4:0] wa,
                          input logic [31:0] res, input logic [31:0] sd, input logic [31:0] rd,
                          input int d);
        exp_t e;
        int   a;
        bit   mem = (kind >= 2);
        bit   tmo = mem && (d > TIMEOUT);
        wait_ready();
        MemRead    = (kind == 1) || (kind == 2);
        MemWrite   = (kind == 1) || (kind == 3);
        RegWrite   = rw;
        MemtoReg   = mtr;
        Write_Addr = wa;
        Result     = res;
        Store_data = sd;
        in_valid   = 1'b1;
        DACK       = mem ? 1'b0 : 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
        in_valid = 1'b0;
        DACK     = 1'b0;
        a        = cyc;
        e.mtr = mtr;
        e.wa  = wa;
        e.res = res;
        e.err = (kind == 1) || tmo;
        e.rw  = e.err ? 1'b0 : rw;
        e.rd  = (kind == 2 && !tmo) ? rd : 32'd0;
        e.cyc = a + (mem ? (tmo ? TIMEOUT : d) : 0);
        q.push_back(e);
        if (!mem) begin
            chk("DREQ_no_access", 32'(DREQ), 32'd0);
            return;
        end
        for (int k = 1; k <= TIMEOUT; k++) begin
            chk("DREQ_held", 32'(DREQ), 32'd1);
            chk("DRW_held", 32'(DRW), 32'(kind == 3));
            chk("DADDR_held", DADDR, res);
            chk("DWDATA_held", DWDATA, sd);
            chk("in_ready_req", 32'(in_ready), 32'd0);
            // Junk on the upstream side must be ignored while the access is outstanding
            in_valid   = 1'($urandom_range(0, 1));
            MemRead    = 1'($urandom_range(0, 1));
            MemWrite   = 1'($urandom_range(0, 1));
            Result     = $urandom;
            Store_data = $urandom;
            if (k == d) begin
                DACK   = 1'b1;
                DRDATA = rd;
            end
            @(posedge CLK); #1;
            DACK     = 1'b0;
            DRDATA   = $urandom;
            in_valid = 1'b0;
            if (k == d) break;
        end
        chk("DREQ_drop", 32'(DREQ), 32'd0);
    endtask

    task automatic idle_gap(input int g);
        for (int i = 0; i < g; i++) begin
            DACK = 1'($urandom_range(0, 1));
            @(posedge CLK); #1;
        end
        DACK = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 RST = 1'b1;
        #1 chk_reset_state();
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        do_txn(0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h0, 0);
        do_txn(2, 1'b1, 1'b1, 5'd7, 32'h40, 32'h1111_2222, 32'hDEADBEEF, 3);
        do_txn(3, 1'b0, 1'b0, 5'd0, 32'h80, 32'hA5A5A5A5, 32'h0, 1);
        do_txn(2, 1'b1, 1'b1, 5'd9, 32'h44, 32'h0, 32'h1234_5678, TIMEOUT + 5);
        do_txn(1, 1'b1, 1'b0, 5'd3, 32'h99, 32'h0, 32'h0, 0);
        do_txn(2, 1'b1, 1'b1, 5'd11, 32'h48, 32'h0, 32'hCAFE_F00D, TIMEOUT);
        do_txn(2, 1'b1, 1'b1, 5'd12, 32'h4C, 32'h0, 32'hBEEF_0001, TIMEOUT - 1);
        do_txn(0, 1'b1, 1'b0, 5'd1, 32'hAAAA_0001, 32'h0, 32'h0, 0);
        do_txn(0, 1'b0, 1'b1, 5'd2, 32'hAAAA_0002, 32'h0, 32'h0, 0);
        do_txn(0, 1'b1, 1'b1, 5'd31, 32'hAAAA_0003, 32'h0, 32'h0, 0);

        // Reset in the middle of an access: the load is dropped and DREQ falls at once
        wait_ready();
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        RegWrite = 1'b1;
        Result   = 32'h100;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        chk("DREQ_before_rst", 32'(DREQ), 32'd1);
        #2 RST = 1'b1;
        #1 chk_reset_state();
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("DREQ_after_rst", 32'(DREQ), 32'd0);

        for (int t = 0; t < 250; t++) begin
            int kind = $urandom_range(0, 3);
            int d    = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                                   : $urandom_range(1, 6);
            do_txn(kind, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, d);
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
        end

        repeat (3) @(posedge CLK);
        #1 chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
